// File: rtl/pgm_pkg.sv
// Shared types and default widths for the packet-generator replay scheduler.
package pgm_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_RAM_W  = 144;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_GAP_W  = 16;
  localparam int BEAT_W     = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    GAP,
    CHECK,
    FIN
  } state_t;
endpackage

// File: rtl/pgm_sched_rdpipe.sv
// Two-stage PGM_RAM read pipeline: tags each issued read, registers the returned beat.
// With PGM_SCHED_TS_EN defined, the first beat of each packet carries a cycle stamp in [31:0].
module pgm_sched_rdpipe
  import pgm_pkg::*;
#(
  parameter int RAM_W = DEF_RAM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              rd_first,
  input  logic              rd_last,
  input  logic [RAM_W-1:0]  rdata,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic              busy
);
  logic              vld1;
  logic              last1;
  logic [BEAT_W-1:0] beat;
  logic              unused_hi;

  assign unused_hi = ^rdata[RAM_W-1:BEAT_W];

`ifdef PGM_SCHED_TS_EN
  logic        first1;
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first1 <= 1'b0;
      ts_cnt <= '0;
    end else begin
      first1 <= rd_en & rd_first;
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  // +1 so the stamp equals the counter value while the beat sits on the output.
  always_comb begin
    beat = rdata[BEAT_W-1:0];
    if (first1) beat[31:0] = ts_cnt + 32'd1;
  end
`else
  logic unused_first;
  assign unused_first = rd_first;
  assign beat         = rdata[BEAT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1         <= 1'b0;
      last1        <= 1'b0;
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
    end else begin
      vld1         <= rd_en;
      last1        <= rd_en & rd_last;
      out_data_wr  <= vld1;
      out_valid_wr <= vld1 & last1;
      out_valid    <= vld1 & last1;
      if (vld1) out_data <= beat;
    end
  end

  assign busy = vld1 | out_data_wr;
endmodule

// File: rtl/pgm_sched.sv
// Replays the PGM_RAM template cfg_pkt_num times (0 = until stop) with cfg_gap idle cycles between copies.
// Optional macro PGM_SCHED_TS_EN: timestamp the first beat of every packet (see pgm_sched_rdpipe).
module pgm_sched
  import pgm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RAM_W  = DEF_RAM_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] tmpl_last_addr,
  input  logic [CNT_W-1:0]  cfg_pkt_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              rd2ram_rd_en,
  output logic [ADDR_W-1:0] rd2ram_addr,
  input  logic [RAM_W-1:0]  ram2rd_rdata,
  output logic [133:0]      out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  input  logic              in_alf,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] last_q, rd_addr;
  logic [CNT_W-1:0]  pkt_num_q, issued;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic              stop_q, rd_last, finish, pipe_busy;

  assign rd_last = (rd_addr == last_q);
  // Count issued packets, not emitted ones: sent_cnt lags the read side by two cycles.
  assign finish  = stop_q || stop || ((pkt_num_q != '0) && (issued >= pkt_num_q));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ARM;
      ARM:   state_nxt = CHECK;
      CHECK: begin
        if (finish) begin
          if (!pipe_busy) state_nxt = FIN;
        end else if (!in_alf) begin
          state_nxt = READ;
        end
      end
      READ:  if (rd_last) state_nxt = (gap_q != '0) ? GAP : CHECK;
      GAP:   if (gap_cnt == gap_q - GAP_W'(1)) state_nxt = CHECK;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= '0;
      pkt_num_q <= '0;
      gap_q     <= '0;
      rd_addr   <= '0;
      gap_cnt   <= '0;
      issued    <= '0;
      sent_cnt  <= '0;
      stop_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE || state == FIN) stop_q <= 1'b0;
      else if (stop)                     stop_q <= 1'b1;

      if (state == READ) rd_addr <= rd_last ? '0 : rd_addr + ADDR_W'(1);

      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state == ARM) begin
        last_q    <= tmpl_last_addr;
        pkt_num_q <= cfg_pkt_num;
        gap_q     <= cfg_gap;
        issued    <= '0;
        sent_cnt  <= '0;
      end else begin
        if (state == READ && rd_last && issued != '1) issued <= issued + CNT_W'(1);
        if (out_valid_wr && sent_cnt != '1) sent_cnt <= sent_cnt + CNT_W'(1);
      end
    end
  end

  assign rd2ram_rd_en = (state == READ);
  assign rd2ram_addr  = rd_addr;
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);

  pgm_sched_rdpipe #(
    .RAM_W (RAM_W)
  ) u_rdpipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd2ram_rd_en),
    .rd_first     (rd_addr == '0),
    .rd_last      (rd_last),
    .rdata        (ram2rd_rdata),
    .out_data     (out_data),
    .out_data_wr  (out_data_wr),
    .out_valid    (out_valid),
    .out_valid_wr (out_valid_wr),
    .busy         (pipe_busy)
  );
endmodule

// File: tb/tb_pgm_sched.sv
// Directed bench for pgm_sched: table of replay configurations plus alf, stop and reset sequences.
module tb_pgm_sched;
  import pgm_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, in_alf;
  logic [6:0]   tmpl_last_addr;
  logic [31:0]  cfg_pkt_num;
  logic [15:0]  cfg_gap;
  logic         rd2ram_rd_en;
  logic [6:0]   rd2ram_addr;
  logic [143:0] ram2rd_rdata = '0;
  logic [133:0] out_data;
  logic         out_data_wr, out_valid, out_valid_wr, busy, done;
  logic [31:0]  sent_cnt;

  pgm_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .tmpl_last_addr(tmpl_last_addr), .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
    .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr), .ram2rd_rdata(ram2rd_rdata),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
    .out_valid_wr(out_valid_wr), .in_alf(in_alf), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  logic [143:0] ram [128];
  always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= ram[rd2ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] make_word(input int a, input int la);
    logic [143:0] w;
    logic [1:0]   h;
    h = (a == 0) ? HDR_HEAD : ((a == la) ? HDR_TAIL : HDR_BODY);
    w = '0;
    w[143:134] = 10'h2A5;
    w[133:132] = h;
    w[131:100] = 32'hC0DE_0000 ^ 32'(a);
    w[99:68]   = 32'(a * 7 + la);
    w[31:0]    = 32'h5A00_0000 + 32'(a);
    return w;
  endfunction

  // Monitor statistics, sampled on the falling edge
  int beats, pkts, rd_cnt, done_cnt, data_err, broken, ts_err;
  int idle_min, idle_max, t_start, first_rd, first_wr, last_wr, done_cyc, busy_fall;
  int exp_addr, cur_la;
  int heads[$];
  int falls[$];
  bit prev_busy, prev_alf, ts_seen;
  logic [31:0]  ts_prev;
  logic [143:0] mon_w;

  task automatic clear_stats();
    beats = 0; pkts = 0; rd_cnt = 0; done_cnt = 0; data_err = 0; broken = 0; ts_err = 0;
    idle_min = -1; idle_max = -1; t_start = -1; first_rd = -1; first_wr = -1;
    last_wr = -1; done_cyc = -1; busy_fall = -1; exp_addr = 0; ts_seen = 0;
    heads.delete(); falls.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy && t_start < 0) t_start = cyc;
      if (rd2ram_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (prev_alf && !in_alf) falls.push_back(cyc);
      if (prev_busy && !busy) busy_fall = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid != out_valid_wr) data_err++;
      if (out_valid_wr && !out_data_wr) data_err++;
      if (!out_data_wr && exp_addr != 0) broken++;
      if (out_data_wr) begin
        beats++;
        if (first_wr < 0) first_wr = cyc;
        if (exp_addr == 0) begin
          heads.push_back(cyc);
          if (last_wr >= 0) begin
            if (idle_min < 0 || cyc - last_wr - 1 < idle_min) idle_min = cyc - last_wr - 1;
            if (idle_max < 0 || cyc - last_wr - 1 > idle_max) idle_max = cyc - last_wr - 1;
          end
        end
        mon_w = make_word(exp_addr, cur_la);
`ifdef PGM_SCHED_TS_EN
        if (exp_addr == 0) begin
          if (ts_seen && out_data[31:0] <= ts_prev) ts_err++;
          ts_prev = out_data[31:0];
          ts_seen = 1;
          if (out_data[133:32] != mon_w[133:32]) data_err++;
        end else if (out_data != mon_w[133:0]) data_err++;
`else
        if (out_data != mon_w[133:0]) data_err++;
`endif
        if (out_valid_wr != (exp_addr == cur_la)) data_err++;
        if (out_valid_wr) begin
          pkts++;
          last_wr = cyc;
          exp_addr = 0;
        end else begin
          exp_addr++;
        end
      end
    end
    prev_busy = busy;
    prev_alf  = in_alf;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int la, input int num, input int gp);
    tmpl_last_addr = 7'(la);
    cfg_pkt_num    = 32'(num);
    cfg_gap        = 16'(gp);
    cur_la         = la;
    for (int a = 0; a < 128; a++) ram[a] = make_word(a, la);
    clear_stats();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    step(3);
  endtask

  typedef struct {
    int la; int num; int gap;
    int beats; int pkts; int idle;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n, hs;
    //          la   num gap beats pkts idle
    vecs[0] = '{2,   4,  0,  12,   4,   1};
    vecs[1] = '{2,   2,  5,  6,    2,   6};
    vecs[2] = '{0,   3,  0,  3,    3,   1};
    vecs[3] = '{5,   1,  3,  6,    1,   -1};
    vecs[4] = '{127, 2,  1,  256,  2,   2};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_alf = 1'b0;
    tmpl_last_addr = '0; cfg_pkt_num = '0; cfg_gap = '0;
    clear_stats();
    #12;
    check("rst_rd_en", rd2ram_rd_en, 0);
    check("rst_addr", rd2ram_addr, 0);
    check("rst_out_data_zero", out_data == '0, 1);
    check("rst_out_data_wr", out_data_wr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_valid_wr", out_valid_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].la, vecs[i].num, vecs[i].gap);
      wait_done(2000);
      check($sformatf("r%0d_beats", i), beats, vecs[i].beats);
      check($sformatf("r%0d_reads", i), rd_cnt, vecs[i].beats);
      check($sformatf("r%0d_pkts", i), pkts, vecs[i].pkts);
      check($sformatf("r%0d_sent_cnt", i), sent_cnt, vecs[i].pkts);
      check($sformatf("r%0d_idle_min", i), idle_min, vecs[i].idle);
      check($sformatf("r%0d_idle_max", i), idle_max, vecs[i].idle);
      check($sformatf("r%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("r%0d_first_rd_lat", i), first_rd - t_start, 3);
      check($sformatf("r%0d_first_wr_lat", i), first_wr - t_start, 5);
      check($sformatf("r%0d_data_err", i), data_err, 0);
      check($sformatf("r%0d_broken", i), broken, 0);
      check($sformatf("r%0d_busy_fall", i), busy_fall - done_cyc, 1);
      if (vecs[i].gap == 0) check($sformatf("r%0d_done_delay", i), done_cyc - last_wr, 2);
`ifdef PGM_SCHED_TS_EN
      check($sformatf("r%0d_ts_err", i), ts_err, 0);
`endif
    end

    // Almost-full: hold in CHECK, then raise mid-packet
    in_alf = 1'b1;
    step(1);
    run(3, 2, 0);
    step(12);
    check("alf_no_read_while_high", rd_cnt, 0);
    in_alf = 1'b0;
    step(2);
    in_alf = 1'b1;
    step(10);
    check("alf_midpkt_reads", rd_cnt, 4);
    check("alf_midpkt_beats", beats, 4);
    in_alf = 1'b0;
    wait_done(200);
    check("alf_heads", heads.size(), 2);
    check("alf_falls", falls.size(), 2);
    if (heads.size() == 2 && falls.size() == 2) begin
      check("alf_resume1", heads[0] - falls[0], 3);
      check("alf_resume2", heads[1] - falls[1], 3);
    end
    check("alf_broken", broken, 0);
    check("alf_sent", sent_cnt, 2);

    // Stop pulsed on the first beat of packet 7 of an endless run
    run(2, 0, 0);
    hs = 0; n = 0;
    while (hs < 7 && n < 300) begin
      step(1);
      n++;
      if (out_data_wr && out_data[133:132] == HDR_HEAD) hs++;
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_done(200);
    check("stop_pkts", pkts, 7);
    check("stop_sent", sent_cnt, 7);
    check("stop_beats", beats, 21);
    check("stop_done_cnt", done_cnt, 1);
    check("stop_data_err", data_err, 0);
    check("stop_idle_after", busy, 0);

    // One-beat packets: start while busy, then asynchronous reset mid-run
    run(0, 50, 2);
    step(20);
    s = int'(sent_cnt);
    check("onebeat_progress", s >= 2, 1);
    check("onebeat_coincide", beats, pkts);
    cfg_pkt_num = 32'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    check("start_busy_ignored", int'(sent_cnt) >= s, 1);
    check("start_busy_still_busy", busy, 1);
    n = 0;
    while (!out_data_wr && n < 20) begin
      step(1);
      n++;
    end
    check("pre_reset_beat_seen", out_data_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_data_wr", out_data_wr, 0);
    check("arst_out_valid_wr", out_valid_wr, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data_zero", out_data == '0, 1);
    check("arst_rd_en", rd2ram_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_sent_cnt", sent_cnt, 0);
    step(1);
    rst_n = 1'b1;
    step(4);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_read", rd2ram_rd_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
